id_ex_pipe_reg: RTL and testbench

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

---
 rtl/id_ex_pipe_reg.sv | 88 ++++++++
 tb/tb_id_ex_pipe_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: decode-to-execute pipeline register with stall, flush bubbles and a saturating bubble counter
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      reg_write_i,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic                      branch_i,
  input  logic                      jump_i,
  input  logic                      alu_src_i,
  input  logic [3:0]                alu_op_i,
  input  logic [2:0]                funct3_i,
  input  logic [1:0]                wb_sel_i,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     pc_o,
  output logic [DATA_WIDTH-1:0]     rs1_data_o,
  output logic [DATA_WIDTH-1:0]     rs2_data_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      reg_write_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic                      branch_o,
  output logic                      jump_o,
  output logic                      alu_src_o,
  output logic [3:0]                alu_op_o,
  output logic [2:0]                funct3_o,
  output logic [1:0]                wb_sel_o,
  output logic [15:0]               bubble_cnt_o
);
  // an invalid decode slot is loaded as a bubble so side effects never escape without valid_o
  always_ff @(posedge clk) begin
    if (rst || flush_i || (!stall_i && !valid_i)) begin
      valid_o     <= 1'b0;
      pc_o        <= '0;
      rs1_data_o  <= '0;
      rs2_data_o  <= '0;
      imm_o       <= '0;
      rs1_addr_o  <= '0;
      rs2_addr_o  <= '0;
      rd_addr_o   <= '0;
      reg_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      branch_o    <= 1'b0;
      jump_o      <= 1'b0;
      alu_src_o   <= 1'b0;
      alu_op_o    <= '0;
      funct3_o    <= '0;
      wb_sel_o    <= '0;
    end else if (!stall_i) begin
      valid_o     <= 1'b1;
      pc_o        <= pc_i;
      rs1_data_o  <= rs1_data_i;
      rs2_data_o  <= rs2_data_i;
      imm_o       <= imm_i;
      rs1_addr_o  <= rs1_addr_i;
      rs2_addr_o  <= rs2_addr_i;
      rd_addr_o   <= rd_addr_i;
      reg_write_o <= reg_write_i;
      mem_read_o  <= mem_read_i;
      mem_write_o <= mem_write_i;
      branch_o    <= branch_i;
      jump_o      <= jump_i;
      alu_src_o   <= alu_src_i;
      alu_op_o    <= alu_op_i;
      funct3_o    <= funct3_i;
      wb_sel_o    <= wb_sel_i;
    end
    if (rst) bubble_cnt_o <= '0;
    else if (flush_i && bubble_cnt_o != 16'hFFFF) bubble_cnt_o <= bubble_cnt_o + 16'd1;
  end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: scoreboard bench with a transaction-level model of the ID/EX register
module tb_id_ex_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  typedef struct packed {
    logic valid;
    logic [DW-1:0] pc, rs1d, rs2d, imm;
    logic [AW-1:0] rs1a, rs2a, rda;
    logic rw, mr, mw, br, jp, as;
    logic [3:0] aluop;
    logic [2:0] f3;
    logic [1:0] wb;
  } o_t;
  typedef struct packed {
    logic rst, stall, flush;
    o_t f;
  } in_t;
  typedef struct packed {
    o_t o;
    logic [15:0] c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  in_t d = '0;
  o_t q;
  logic [15:0] cnt;
  logic valid_o, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, alu_src_o;
  logic [DW-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [AW-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [3:0] alu_op_o;
  logic [2:0] funct3_o;
  logic [1:0] wb_sel_o;

  id_ex_pipe_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(d.rst), .stall_i(d.stall), .flush_i(d.flush), .valid_i(d.f.valid),
    .pc_i(d.f.pc), .rs1_data_i(d.f.rs1d), .rs2_data_i(d.f.rs2d), .imm_i(d.f.imm),
    .rs1_addr_i(d.f.rs1a), .rs2_addr_i(d.f.rs2a), .rd_addr_i(d.f.rda),
    .reg_write_i(d.f.rw), .mem_read_i(d.f.mr), .mem_write_i(d.f.mw), .branch_i(d.f.br),
    .jump_i(d.f.jp), .alu_src_i(d.f.as), .alu_op_i(d.f.aluop), .funct3_i(d.f.f3), .wb_sel_i(d.f.wb),
    .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .branch_o(branch_o), .jump_o(jump_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o),
    .funct3_o(funct3_o), .wb_sel_o(wb_sel_o), .bubble_cnt_o(cnt)
  );
  assign q = {valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
              reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, alu_src_o,
              alu_op_o, funct3_o, wb_sel_o};

  int errs = 0, checks = 0;
  exp_t sb[$];
  o_t m = '0;
  logic [15:0] mc = '0;

  task automatic chk(input string n, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  // reference: instruction slot is either a captured valid instruction or an all-zero bubble
  task automatic step(input in_t x);
    d = x;
    if (x.rst) begin
      m = '0;
      mc = '0;
    end else if (x.flush) begin
      m = '0;
      mc = (mc == 16'hFFFF) ? mc : mc + 16'd1;
    end else if (!x.stall) m = x.f.valid ? x.f : '0;
    sb.push_back('{o: m, c: mc});
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("outputs", {1'b0, q}, {1'b0, e.o});
      chk("bubble_cnt", {144'b0, cnt}, {144'b0, e.c});
      if (!valid_o) chk("side_effects_without_valid", {155'b0, reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o}, '0);
    end
  end

  function automatic o_t rnd();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[158:0];
  endfunction

  initial begin
    in_t x;
    logic [15:0] c0;
    x = '0; x.rst = 1'b1; x.stall = 1'b1; x.flush = 1'b1;
    step(x);
    chk("reset_outputs", {1'b0, q}, '0);
    chk("reset_cnt", {144'b0, cnt}, '0);
    x = '0; x.f.valid = 1'b1; x.f.pc = 32'h40; x.f.imm = 32'h4444_4444; x.f.rda = 5'd5; x.f.rw = 1'b1;
    step(x);
    chk("load_pc", {128'b0, pc_o}, 160'h40);
    chk("load_imm", {128'b0, imm_o}, 160'h4444_4444);
    chk("load_rd_rw_valid", {153'b0, rd_addr_o, reg_write_o, valid_o}, {153'b0, 5'd5, 1'b1, 1'b1});
    x.f.pc = 32'h44; x.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(x);
      chk("stall_hold", {127'b0, valid_o, pc_o}, {127'b0, 1'b1, 32'h40});
    end
    x.stall = 1'b0;
    step(x);
    chk("stall_release_pc", {128'b0, pc_o}, 160'h44);
    c0 = cnt;
    x.flush = 1'b1; x.stall = 1'b1; x.f.mw = 1'b1;
    step(x);
    chk("flush_stall_bubble", {126'b0, valid_o, mem_write_o, pc_o}, '0);
    chk("flush_cnt_inc", {144'b0, cnt}, {144'b0, c0 + 16'd1});
    c0 = cnt;
    x = '0; x.f.rw = 1'b1; x.f.imm = 32'h1111_1111;
    step(x);
    chk("invalid_bubble", {126'b0, valid_o, reg_write_o, imm_o}, '0);
    chk("invalid_no_count", {144'b0, cnt}, {144'b0, c0});
    x = '0; x.f = rnd(); x.f.valid = 1'b1;
    step(x);
    x.rst = 1'b1; x.stall = 1'b1;
    step(x);
    chk("reset_mid_stall", {1'b0, q, cnt} >> 16, '0);
    x = '0; x.f = rnd(); x.f.valid = 1'b1;
    step(x);
    chk("load_after_reset", {1'b0, q}, {1'b0, x.f});
    for (int i = 0; i < 400; i++) begin
      x.f = rnd();
      x.f.valid = ($urandom_range(3) != 0);
      x.stall = ($urandom_range(3) == 0);
      x.flush = ($urandom_range(6) == 0);
      x.rst = ($urandom_range(40) == 0);
      step(x);
    end
    x = '0; x.rst = 1'b1;
    step(x);
    x = '0; x.flush = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      x.f = rnd();
      x.stall = $urandom_range(1);
      step(x);
    end
    chk("saturate", {144'b0, cnt}, {144'b0, 16'hFFFF});
    step(x);
    chk("saturate_hold", {144'b0, cnt}, {144'b0, 16'hFFFF});
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 160'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
